u_bipolar_decoder: RTL and testbench
====================================

Name: u_bipolar_decoder

Overview:
Converts a bipolar unary bitstream into a signed binary value. It counts the ones in the stream over a fixed window of 2^BWIDTH enabled cycles. It sits at the output end of a unary datapath, for example after a scaled subtractor or adder, and turns the result stream back into a two's-complement word for binary logic or test readout. Decode uses a start/valid/ready handshake and supports stalling of the incoming stream.

Parameters:
BWIDTH, 8, log2 of the window length; the window is 2^BWIDTH sampled bits.

Ports:
iClk  input  1  clock; all state changes on the rising edge
iRstN  input  1  reset; asynchronous assert, active-low
iStart  input  1  request a new decode window; honoured only in IDLE, or in HOLD together with iReady
iEn  input  1  the stream bit is valid this cycle; iBit is sampled only when iEn=1 in ACC
iBit  input  1  unary stream bit
iReady  input  1  consumer accepts the result while oValid=1
oBusy  output  1  1 while in ACC
oValid  output  1  1 while in HOLD; the result is stable
oOnes  output  BWIDTH+1  count of ones in the last window, range 0..2^BWIDTH
oValue  output  BWIDTH+2  signed bipolar value = 2*oOnes - 2^BWIDTH, range -2^BWIDTH..+2^BWIDTH

Behaviour:
- Clock and reset: one clock, iClk. iRstN is asynchronous, active-low.
- Reset values: state=IDLE, oBusy=0, oValid=0, oOnes=0, oValue=0, internal window counter=0, internal ones accumulator=0.
- Reset mid-window: the partial window is discarded. Decoding resumes only after a new iStart.
- States: IDLE, ACC, HOLD. The encoding is free; oBusy and oValid are registered outputs.
- IDLE:
  - iStart=1 -> ACC. The window counter and ones accumulator clear to 0.
  - iBit is not sampled in the iStart cycle.
  - oOnes and oValue keep their previous values.
- ACC:
  - Each edge with iEn=1: accumulator += iBit and window counter += 1.
  - Edges with iEn=0 change nothing (stall).
  - iStart is ignored.
  - On the edge that samples the 2^BWIDTH-th enabled bit:
    - oOnes <= final count, including that bit.
    - oValue <= 2*count - 2^BWIDTH, sign-extended to BWIDTH+2 bits.
    - state -> HOLD, oBusy <= 0, oValid <= 1.
- Width rules:
  - The window counter is BWIDTH+1 bits, or BWIDTH bits with a terminal-count compare; there is no wrap before the window ends.
  - The accumulator is BWIDTH+1 bits and must represent 2^BWIDTH without overflow.
- Latency: with iEn held at 1, oValid rises exactly 2^BWIDTH cycles after the edge at which iStart was accepted.
- HOLD:
  - oOnes, oValue and oValid stay stable until the handshake.
  - iReady=1 and iStart=0 -> IDLE, oValid <= 0.
  - iReady=1 and iStart=1 -> directly to ACC (back-to-back window). Counters clear, oValid <= 0, oBusy <= 1.
  - iStart=1 with iReady=0 -> ignored; stays in HOLD.
  - iEn and iBit are ignored.
- oOnes and oValue hold the last result through IDLE and ACC. They are meaningful only while oValid=1.
- No combinational path from any input to any output.

Test Plan:
- BWIDTH=4; iStart pulse, iEn=1, iBit=1 for 16 cycles -> oValid rises 16 cycles after iStart; oOnes=16, oValue=+16 (6'b010000).
- BWIDTH=4; iBit=0 for the whole window -> oOnes=0, oValue=-16 (6'b110000). Alternating 1/0 -> oOnes=8, oValue=0. 12 ones of 16 -> oOnes=12, oValue=+8.
- BWIDTH=4; iEn toggling 1/0 every cycle, iBit=1 whenever enabled, with random iBit while iEn=0 -> 32 cycles to oValid; oOnes=16. Stalled bits are not counted.
- BWIDTH=4; iReady=0 for 5 cycles after oValid -> outputs constant; iStart in that span is ignored. iReady=1 together with iStart=1 -> oValid falls and oBusy rises on the same edge. The second window of all zeros -> oValue=-16.
- BWIDTH=4; iRstN pulsed low asynchronously (mid-cycle) at sample 9 of a window -> all outputs return to 0 immediately. After release, no activity without iStart; a new full window of 4 ones -> oOnes=4, oValue=-8.
- iStart asserted during ACC at sample 5 -> ignored; the window still completes at 16 enabled samples with the correct count.

Source files
------------

// File: rtl/u_bipolar_decoder.sv
// Bipolar unary-to-binary decoder: counts ones over a window of 2^BWIDTH
// enabled samples and presents 2*ones - 2^BWIDTH behind a valid/ready handshake.
module u_bipolar_decoder #(
    parameter int BWIDTH = 8
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iStart,
    input  logic              iEn,
    input  logic              iBit,
    input  logic              iReady,
    output logic              oBusy,
    output logic              oValid,
    output logic [BWIDTH:0]   oOnes,
    output logic [BWIDTH+1:0] oValue
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Index of the last sample in a window and the bipolar zero offset.
    localparam logic [BWIDTH:0]   LAST_IDX = {1'b0, {BWIDTH{1'b1}}};
    localparam logic [BWIDTH+1:0] OFFSET   = {2'b01, {BWIDTH{1'b0}}};

    state_e              state_q, state_d;
    logic [BWIDTH:0]     cnt_q, cnt_d;
    logic [BWIDTH:0]     acc_q, acc_d;
    logic [BWIDTH:0]     ones_q, ones_d;
    logic [BWIDTH+1:0]   value_q, value_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [BWIDTH:0]     acc_inc;

    assign acc_inc = acc_q + {{BWIDTH{1'b0}}, iBit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ones_d  = ones_q;
        value_d = value_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_ACC;
                    cnt_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_ACC: begin
                if (iEn) begin
                    acc_d = acc_inc;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        // Final sample: publish including this bit.
                        ones_d  = acc_inc;
                        value_d = {acc_inc, 1'b0} - OFFSET;
                        state_d = ST_HOLD;
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (iReady) begin
                    valid_d = 1'b0;
                    if (iStart) begin
                        state_d = ST_ACC;
                        cnt_d   = '0;
                        acc_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ones_q  <= '0;
            value_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ones_q  <= ones_d;
            value_q <= value_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign oBusy  = busy_q;
    assign oValid = valid_q;
    assign oOnes  = ones_q;
    assign oValue = value_q;

endmodule

// File: tb/tb_u_bipolar_decoder.sv
// Randomized scoreboard bench for u_bipolar_decoder at BWIDTH=4.
module tb_u_bipolar_decoder;

    localparam int BW  = 4;
    localparam int WIN = 1 << BW;

    logic          iClk = 1'b0;
    logic          iRstN = 1'b0;
    logic          iStart = 1'b0;
    logic          iEn = 1'b0;
    logic          iBit = 1'b0;
    logic          iReady = 1'b0;
    logic          oBusy, oValid;
    logic [BW:0]   oOnes;
    logic [BW+1:0] oValue;

    typedef struct {
        int ones;
        int value;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   have_cur = 0;
    bit   prev_valid = 0;
    int   total = 0;
    int   bad = 0;

    u_bipolar_decoder #(.BWIDTH(BW)) dut (
        .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iEn(iEn), .iBit(iBit),
        .iReady(iReady), .oBusy(oBusy), .oValid(oValid), .oOnes(oOnes), .oValue(oValue)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: pops a reference result when oValid rises, then holds the
    // DUT to it for every cycle the result is presented.
    always @(negedge iClk) begin
        if (!iRstN) begin
            prev_valid = 0;
            have_cur   = 0;
        end else begin
            if (oValid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid: got valid with empty scoreboard, expected none");
                    have_cur = 0;
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1;
                end
            end
            if (oValid && have_cur) begin
                chk("ones", int'(oOnes), cur.ones);
                chk("value", int'($signed(oValue)), cur.value);
            end
            prev_valid = oValid;
        end
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Drives one window. abort_at>=0 pulses reset after that many samples.
    task automatic window(input logic [WIN-1:0] bits, input bit stall,
                          input bit skip_start, input int abort_at, input bit start_mid);
        exp_t e;
        if (abort_at < 0) begin
            e.ones  = $countones(bits);
            e.value = 2 * e.ones - WIN;
            exp_q.push_back(e);
        end
        if (!skip_start) begin
            iStart = 1; iEn = 1; iBit = 1;   // bit must not be sampled here
            step();
            iStart = 0;
            chk("busy_after_start", int'(oBusy), 1);
        end
        for (int i = 0; i < WIN; i++) begin
            if (stall) begin
                iEn = 0; iBit = 1'($urandom);
                step();
                chk("stall_busy", int'(oBusy), 1);
            end
            iEn = 1; iBit = bits[i];
            iStart = (start_mid && i == 5);
            step();
            iStart = 0;
            if (i == abort_at) begin
                iEn = 0;
                #2 iRstN = 0;
                #1;
                chk("rst_busy", int'(oBusy), 0);
                chk("rst_valid", int'(oValid), 0);
                chk("rst_ones", int'(oOnes), 0);
                chk("rst_value", int'(oValue), 0);
                #2 iRstN = 1;
                return;
            end
            if (i < WIN - 1) chk("valid_early", int'(oValid), 0);
        end
        iEn = 0;
        chk("valid_at_end", int'(oValid), 1);
        chk("busy_at_end", int'(oBusy), 0);
    endtask

    // Stall the consumer, then accept with optional back-to-back start.
    task automatic hold(input int nwait, input bit next_start);
        iReady = 0;
        for (int i = 0; i < nwait; i++) begin
            iStart = 1'($urandom); iEn = 1'($urandom); iBit = 1'($urandom);
            step();
            chk("hold_valid", int'(oValid), 1);
            chk("hold_busy", int'(oBusy), 0);
        end
        iEn = 0;
        iReady = 1; iStart = next_start;
        step();
        iReady = 0; iStart = 0;
        chk("accept_valid", int'(oValid), 0);
        chk("accept_busy", int'(oBusy), int'(next_start));
    endtask

    initial begin
        logic [WIN-1:0] pat;
        #12;
        chk("reset_busy", int'(oBusy), 0);
        chk("reset_valid", int'(oValid), 0);
        chk("reset_ones", int'(oOnes), 0);
        chk("reset_value", int'(oValue), 0);
        iRstN = 1;
        step();

        window('1, 0, 0, -1, 0);                 hold(0, 0);
        window('0, 0, 0, -1, 0);                 hold(0, 0);
        pat = 16'h5555; window(pat, 0, 0, -1, 0); hold(0, 0);
        pat = 16'h0FFF; window(pat, 0, 0, -1, 0); hold(0, 0);
        window('1, 1, 0, -1, 0);                 hold(5, 1);
        window('0, 0, 1, -1, 0);                 hold(0, 0);

        pat = 16'hFFFF; window(pat, 0, 0, 9, 0);
        for (int i = 0; i < 6; i++) begin
            iEn = 1; iBit = 1'($urandom);
            step();
            chk("idle_busy", int'(oBusy), 0);
            chk("idle_valid", int'(oValid), 0);
        end
        iEn = 0;
        pat = 16'h8421; window(pat, 0, 0, -1, 0); hold(1, 0);
        pat = 16'h3C5A; window(pat, 0, 0, -1, 1); hold(2, 0);

        for (int r = 0; r < 8; r++) begin
            pat = WIN'($urandom);
            window(pat, 1'($urandom), 0, -1, 1'($urandom));
            hold(int'($urandom_range(0, 4)), 0);
        end

        for (int i = 0; i < 4; i++) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
